// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks that a one-hot ring word rotates left or holds, encodes the hot bit to a phase,
// counts revolutions and tracks HUNT/LOCKED/ERROR lock status. Define RPM_STALL_DET_EN for the stall detector.
`timescale 1ns/1ps
module ring_phase_monitor #(
  parameter int WIDTH       = 8,
  parameter int REV_W       = 8,
  parameter int ERR_LIMIT   = 3,
  parameter int STALL_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     sync_clr,
  output logic [$clog2(WIDTH)-1:0] phase,
  output logic                     phase_valid,
  output logic                     rev_tick,
  output logic [REV_W-1:0]         rev_count,
  output logic [1:0]               state,
  output logic                     err_sticky,
  output logic                     stall
);
  localparam int PW = $clog2(WIDTH);
  localparam int MW = $clog2(ERR_LIMIT + 1);
  localparam logic [MW-1:0] MISS_MAX = MW'(ERR_LIMIT);

  typedef enum logic [1:0] {HUNT = 2'b00, LOCKED = 2'b01, ERROR = 2'b10} state_t;

  if (WIDTH < 2 || ERR_LIMIT < 1 || STALL_LIMIT < 1) begin : g_param_check
    $error("ring_phase_monitor: illegal parameter value");
  end

  logic [WIDTH-1:0] s_cur, s_prev;
  logic [MW-1:0]    miss, nxt_miss;
  state_t           cur_state, nxt_state;
  logic [PW-1:0]    nxt_phase;
  logic [REV_W-1:0] nxt_rev;
  logic             nxt_valid, nxt_tick, nxt_err;
  logic             adv, hold, good, wrap;

  function automatic logic is_onehot(input logic [WIDTH-1:0] x);
    return (x != '0) && ((x & (x - WIDTH'(1))) == '0);
  endfunction

  function automatic logic [PW-1:0] hot_index(input logic [WIDTH-1:0] x);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (x[i]) idx = idx | PW'(i);
    return idx;
  endfunction

  assign adv   = (s_cur == {s_prev[WIDTH-2:0], s_prev[WIDTH-1]});
  assign hold  = (s_cur == s_prev);
  assign good  = is_onehot(s_cur) && is_onehot(s_prev) && (adv || hold);
  // Completed revolution: the top bit wrapped around into bit 0.
  assign wrap  = good && adv && s_prev[WIDTH-1] && s_cur[0];
  assign state = cur_state;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    nxt_state = cur_state;
    nxt_miss  = miss;
    nxt_phase = phase;
    nxt_valid = 1'b0;
    nxt_tick  = 1'b0;
    nxt_rev   = rev_count;
    nxt_err   = err_sticky;
    if (sync_clr) begin
      nxt_state = HUNT;
      nxt_miss  = '0;
      nxt_rev   = '0;
      nxt_err   = 1'b0;
    end else begin
      unique case (cur_state)
        HUNT: begin
          if (good) begin
            nxt_state = LOCKED;
            nxt_phase = hot_index(s_cur);
            nxt_valid = 1'b1;
          end
        end
        LOCKED: begin
          if (good) begin
            nxt_miss  = '0;
            nxt_phase = hot_index(s_cur);
            nxt_valid = 1'b1;
            if (wrap) begin
              nxt_tick = 1'b1;
              nxt_rev  = rev_count + REV_W'(1);
            end
          end else begin
            nxt_miss = miss + MW'(1);
            if (miss + MW'(1) == MISS_MAX) begin
              nxt_state = ERROR;
              nxt_err   = 1'b1;
            end
          end
        end
        ERROR:   ;
        default: nxt_state = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_cur       <= '0;
      s_prev      <= '0;
      miss        <= '0;
      cur_state   <= HUNT;
      phase       <= '0;
      phase_valid <= 1'b0;
      rev_tick    <= 1'b0;
      rev_count   <= '0;
      err_sticky  <= 1'b0;
    end else begin
      s_cur       <= ring_in;
      s_prev      <= s_cur;
      miss        <= nxt_miss;
      cur_state   <= nxt_state;
      phase       <= nxt_phase;
      phase_valid <= nxt_valid;
      rev_tick    <= nxt_tick;
      rev_count   <= nxt_rev;
      err_sticky  <= nxt_err;
    end
  end

`ifdef RPM_STALL_DET_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);
  logic [SW-1:0] stall_cnt;

  // Counts consecutive holds while LOCKED; any movement or state change restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= '0;
    else if (sync_clr || adv || (nxt_state != cur_state))
      stall_cnt <= '0;
    else if (cur_state == LOCKED && hold && stall_cnt != STALL_MAX)
      stall_cnt <= stall_cnt + SW'(1);
  end

  assign stall = (stall_cnt == STALL_MAX);
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Scoreboard bench for ring_phase_monitor: directed ring sequences push tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_ring_phase_monitor;
  typedef enum int {F_STATE, F_PHASE, F_VALID, F_TICK, F_REV, F_ERR, F_STALL} field_t;
  typedef struct {
    int     tag;
    field_t fld;
    int     val;
    string  name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sync_clr = 1'b0;
  logic [7:0] ring_in = '0;
  logic [2:0] phase;
  logic       phase_valid, rev_tick, err_sticky, stall;
  logic [7:0] rev_count;
  logic [1:0] state;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   edge_n = 0;
  int   tick_cnt = 0;
  exp_t sb[$];

`ifdef RPM_STALL_DET_EN
  localparam int STALL_EXP = 1;
`else
  localparam int STALL_EXP = 0;
`endif

  ring_phase_monitor #(.WIDTH(8), .REV_W(8), .ERR_LIMIT(3), .STALL_LIMIT(16)) dut (
    .clk(clk), .reset(reset), .ring_in(ring_in), .sync_clr(sync_clr),
    .phase(phase), .phase_valid(phase_valid), .rev_tick(rev_tick), .rev_count(rev_count),
    .state(state), .err_sticky(err_sticky), .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rev_tick === 1'b1) tick_cnt++;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic [7:0] r, input logic clr);
    @(negedge clk);
    ring_in  = r;
    sync_clr = clr;
    edge_n   = cyc + 1;
  endtask

  task automatic expect_f(input int tag, input field_t f, input int v, input string name);
    exp_t e;
    e.tag = tag; e.fld = f; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drain", sb.size(), 0);
    @(negedge clk);
  endtask

  function automatic logic [7:0] hot(input int k);
    return 8'(1) << (k % 8);
  endfunction

  // Monitor: compares every expectation whose edge has been reached.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        e = sb.pop_front();
        case (e.fld)
          F_STATE: act = 32'(state);
          F_PHASE: act = 32'(phase);
          F_VALID: act = 32'(phase_valid);
          F_TICK:  act = 32'(rev_tick);
          F_REV:   act = 32'(rev_count);
          F_ERR:   act = 32'(err_sticky);
          default: act = 32'(stall);
        endcase
        check(e.name, act, 32'(e.val));
      end
    end
  end

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("reset_state", state, 0);
    check("reset_valid", phase_valid, 0);
    check("reset_rev", rev_count, 0);
    check("reset_err", err_sticky, 0);
    check("reset_stall", stall, 0);
    reset = 1'b1;

    // Free-running ring from 0000_0001, three revolutions.
    for (int i = 0; i <= 24; i++) begin
      apply(hot(i), 1'b0);
      if (i == 0) begin
        expect_f(edge_n + 1, F_STATE, 0, "t1_hunt_first");
        expect_f(edge_n + 1, F_VALID, 0, "t1_invalid_first");
      end else begin
        expect_f(edge_n + 1, F_STATE, 1, $sformatf("t1_state_%0d", i));
        expect_f(edge_n + 1, F_PHASE, i % 8, $sformatf("t1_phase_%0d", i));
        expect_f(edge_n + 1, F_VALID, 1, $sformatf("t1_valid_%0d", i));
        expect_f(edge_n + 1, F_TICK, (i % 8 == 0) ? 1 : 0, $sformatf("t1_tick_%0d", i));
        expect_f(edge_n + 1, F_REV, i / 8, $sformatf("t1_rev_%0d", i));
      end
    end

    // Upstream reset mid-ring: one bad compare, holds re-lock.
    for (int i = 25; i <= 28; i++) apply(hot(i), 1'b0);
    apply(8'h01, 1'b0);
    expect_f(edge_n + 1, F_VALID, 0, "t2_jump_invalid");
    expect_f(edge_n + 1, F_STATE, 1, "t2_jump_locked");
    expect_f(edge_n + 1, F_PHASE, 4, "t2_jump_phase_hold");
    expect_f(edge_n + 1, F_ERR, 0, "t2_jump_err");
    apply(8'h01, 1'b0);
    expect_f(edge_n + 1, F_VALID, 1, "t2_hold1_valid");
    expect_f(edge_n + 1, F_PHASE, 0, "t2_hold1_phase");
    apply(8'h01, 1'b0);
    expect_f(edge_n + 1, F_VALID, 1, "t2_hold2_valid");
    expect_f(edge_n + 1, F_STATE, 1, "t2_hold2_state");
    apply(8'h02, 1'b0);
    expect_f(edge_n + 1, F_PHASE, 1, "t2_resume_phase");
    expect_f(edge_n + 1, F_ERR, 0, "t2_resume_err");
    expect_f(edge_n + 1, F_REV, 3, "t2_resume_rev");

    // Illegal two-hot word drives LOCKED into ERROR on the third bad compare.
    apply(8'h03, 1'b0);
    expect_f(edge_n + 1, F_STATE, 1, "t3_bad1_locked");
    apply(8'h03, 1'b0);
    expect_f(edge_n + 1, F_STATE, 1, "t3_bad2_locked");
    apply(8'h03, 1'b0);
    expect_f(edge_n + 1, F_STATE, 2, "t3_bad3_error");
    expect_f(edge_n + 1, F_ERR, 1, "t3_bad3_sticky");
    for (int k = 2; k <= 4; k++) begin
      apply(hot(k), 1'b0);
      expect_f(edge_n + 1, F_STATE, 2, $sformatf("t3_err_state_%0d", k));
      expect_f(edge_n + 1, F_VALID, 0, $sformatf("t3_err_valid_%0d", k));
      expect_f(edge_n + 1, F_TICK, 0, $sformatf("t3_err_tick_%0d", k));
      expect_f(edge_n + 1, F_PHASE, 1, $sformatf("t3_err_phase_%0d", k));
    end
    apply(hot(5), 1'b0);
    apply(hot(6), 1'b1);
    expect_f(edge_n, F_STATE, 0, "t3_clr_hunt");
    expect_f(edge_n, F_REV, 0, "t3_clr_rev");
    expect_f(edge_n, F_ERR, 0, "t3_clr_err");
    expect_f(edge_n, F_VALID, 0, "t3_clr_valid");
    apply(hot(7), 1'b0);
    expect_f(edge_n + 1, F_STATE, 1, "t3_relock");
    expect_f(edge_n + 1, F_PHASE, 7, "t3_relock_phase");
    apply(hot(8), 1'b0);
    expect_f(edge_n + 1, F_TICK, 1, "t3_first_tick");
    expect_f(edge_n + 1, F_REV, 1, "t3_first_rev");
    drain();

    // 256 revolutions: rev_count wraps through 255 -> 0 and back to 1.
    base = tick_cnt;
    for (int k = 1; k <= 256; k++) begin
      for (int j = 1; j <= 8; j++) apply(hot(j), 1'b0);
      expect_f(edge_n + 1, F_TICK, 1, $sformatf("t4_tick_%0d", k));
      expect_f(edge_n + 1, F_REV, (1 + k) % 256,
               ((1 + k) % 256 == 0) ? "t4_rev_wrap" : $sformatf("t4_rev_%0d", k));
    end
    drain();
    check("t4_tick_count", tick_cnt - base, 256);

    // Asynchronous reset between edges while LOCKED with rev_count=5.
    for (int k = 1; k <= 4; k++)
      for (int j = 1; j <= 8; j++) apply(hot(j), 1'b0);
    expect_f(edge_n + 1, F_REV, 5, "t5_rev_before_reset");
    drain();
    apply(8'h02, 1'b0);
    apply(8'h04, 1'b0);
    apply(8'h04, 1'b0);
    @(posedge clk);
    #2;
    check("t5_pre_phase", phase, 2);
    check("t5_pre_valid", phase_valid, 1);
    reset = 1'b0;
    #1;
    check("t5_async_state", state, 0);
    check("t5_async_phase", phase, 0);
    check("t5_async_valid", phase_valid, 0);
    check("t5_async_tick", rev_tick, 0);
    check("t5_async_rev", rev_count, 0);
    check("t5_async_err", err_sticky, 0);
    check("t5_async_stall", stall, 0);
    @(negedge clk);
    check("t5_held_state", state, 0);
    reset = 1'b1;

    // Re-lock, then hold 0000_0100 for 16 compares.
    apply(8'h01, 1'b0);
    expect_f(edge_n + 1, F_STATE, 0, "t5_hunt_after_release");
    apply(8'h02, 1'b0);
    expect_f(edge_n + 1, F_STATE, 1, "t6_locked");
    apply(8'h04, 1'b0);
    expect_f(edge_n + 1, F_PHASE, 2, "t6_phase");
    for (int h = 1; h <= 16; h++) begin
      apply(8'h04, 1'b0);
      if (h == 15) expect_f(edge_n + 1, F_STALL, 0, "t6_stall_h15");
      if (h == 16) begin
        expect_f(edge_n + 1, F_STALL, STALL_EXP, "t6_stall_h16");
        expect_f(edge_n + 1, F_PHASE, 2, "t6_phase_h16");
        expect_f(edge_n + 1, F_VALID, 1, "t6_valid_h16");
        expect_f(edge_n + 1, F_STATE, 1, "t6_state_h16");
      end
    end
    apply(8'h08, 1'b0);
    expect_f(edge_n + 1, F_STALL, 0, "t6_stall_cleared");
    expect_f(edge_n + 1, F_PHASE, 3, "t6_phase_adv");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
Downstream consumer of the 8-bit one-hot rotating shift counter. Samples the ring word every cycle and checks that it advances legally (rotate-left, bit[W-1]->bit[0]) or holds. Encodes the hot bit to a binary phase and counts full revolutions. Provides a lock/error state machine so control logic can trust the phase value.

Parameters:
WIDTH, 8, ring width in bits; must be >= 2.
REV_W, 8, revolution counter width.
ERR_LIMIT, 3, consecutive bad compares in LOCKED before entering ERROR; must be >= 1.
STALL_LIMIT, 16, consecutive hold compares that raise stall; used only with RPM_STALL_DET_EN.

Ports:
clk  in  1  rising-edge clock, shared with the upstream counter.
reset  in  1  asynchronous, active-low reset: 0 = reset.
ring_in  in  WIDTH  one-hot ring word from upstream counter.
sync_clr  in  1  synchronous clear: go to HUNT; zero rev_count, err_sticky and the miss counter.
phase  out  $clog2(WIDTH)  binary index of the hot bit.
phase_valid  out  1  phase is trustworthy this cycle.
rev_tick  out  1  one-cycle pulse per completed revolution.
rev_count  out  REV_W  revolution count, wraps modulo 2^REV_W.
state  out  2  HUNT=2'b00, LOCKED=2'b01, ERROR=2'b10.
err_sticky  out  1  set on entry to ERROR; cleared only by sync_clr or reset.
stall  out  1  hold-too-long flag; constant 0 unless RPM_STALL_DET_EN.

Behaviour:
- reset=0, asynchronously: s_cur=0, s_prev=0, miss=0, stall counter=0, phase=0, phase_valid=0, rev_tick=0, rev_count=0, state=HUNT, err_sticky=0, stall=0. This applies at any time, including mid-operation.
- Pipeline: at each edge, s_cur<=ring_in and s_prev<=s_cur. All outputs are registered from compare(s_prev, s_cur). Latency is 2 edges from ring_in to outputs.
- onehot(x): exactly one bit set. adv: s_cur==rotl(s_prev). hold: s_cur==s_prev.
- good: onehot(s_cur) && onehot(s_prev) && (adv || hold). Every other compare is bad.
- HUNT:
  - good -> LOCKED; phase=index(s_cur), phase_valid=1.
  - bad -> stay in HUNT, phase_valid=0.
  - No miss counting in HUNT.
- LOCKED:
  - good -> miss=0; phase=index(s_cur); phase_valid=1.
  - bad -> miss+1; phase_valid=0; phase holds.
  - If miss+1==ERR_LIMIT -> ERROR, err_sticky=1.
- ERROR:
  - phase_valid=0; phase holds; no rev_tick.
  - Stays in ERROR regardless of input until sync_clr.
- rev_tick=1 when state is LOCKED, compare is good and adv, s_prev[WIDTH-1]=1 and s_cur[0]=1. rev_count increments that same edge; 2^REV_W-1 -> 0 still pulses rev_tick.
- Upstream synchronous reset mid-ring: the jump to 0..01 is one bad compare. The repeated 0..01 samples are holds (good) and clear miss. LOCKED is retained when ERR_LIMIT>1.
- sync_clr has priority over all transitions and counts. On that edge: state=HUNT, rev_count=0, err_sticky=0, miss=0, phase_valid=0, rev_tick=0.
- s_cur/s_prev keep sampling during sync_clr.
- Bit-exact wrap of rotl: bit[WIDTH-1] goes to bit[0].

Optional Feature:
RPM_STALL_DET_EN:
- Defined:
  - A stall counter increments on each hold compare while LOCKED and saturates at STALL_LIMIT.
  - The counter resets to 0 on any adv compare, on a state change, on sync_clr, or on reset.
  - stall=1 while counter==STALL_LIMIT.
  - stall does not affect state or phase_valid.
- Undefined: no stall counter is built; stall is tied to 0.

Test Plan:
1. Release reset, then drive a free ring from 0000_0001 -> state=LOCKED 2 edges after the second sample; phase steps 0..7 then 0. rev_tick pulses on each 1000_0000->0000_0001 compare; rev_count=3 after 3 revolutions.
2. LOCKED with ring at 0001_0000, then ring_in forced to 0000_0001 for 3 cycles -> phase_valid=0 for exactly 1 cycle; state stays LOCKED; err_sticky=0; phase=0 afterwards.
3. Drive ring_in=0000_0011 for 3 cycles (ERR_LIMIT=3) -> state=ERROR on the 3rd bad compare; err_sticky=1. State stays ERROR when the ring resumes legally. Pulse sync_clr -> state=HUNT, rev_count=0, err_sticky=0, then LOCKED again.
4. REV_W=8, run 256 revolutions -> 256 rev_tick pulses; rev_count wraps 255->0.
5. Assert reset=0 between clock edges while LOCKED with rev_count=5 -> all outputs reach their reset values before the next edge; HUNT after release.
6. RPM_STALL_DET_EN defined: hold 0000_0100 for 16 compares -> stall=1 and phase=2; next advance -> stall=0. Without the macro, the same stimulus gives stall=0 throughout.
